// File: rtl/eeg_sample_loader_pkg.sv
// eeg_sample_loader_pkg: shared types and constants for the EEG load stage.
// Optional checksum output of the loader is enabled by EEG_SAMPLE_LOADER_CHECKSUM_EN.
package eeg_sample_loader_pkg;

  localparam int ADC_BITWIDTH     = 16;
  localparam int NUM_PATCHES      = 30;
  localparam int PATCH_LEN        = 128;
  localparam int EEG_NUM_SAMPLES  = NUM_PATCHES * PATCH_LEN;
  localparam int ADC_MIDSCALE     = 1 << (ADC_BITWIDTH - 1);
  localparam int INT_RES_ADDR_W   = 16;
  localparam int INT_RES_DOUBLE_W = 30;

  typedef logic [ADC_BITWIDTH-1:0]     AdcData_t;
  typedef logic [INT_RES_ADDR_W-1:0]   IntResAddr_t;
  typedef logic [INT_RES_DOUBLE_W-1:0] IntResDouble_t;

  typedef enum logic [0:0] {
    EEG_INPUT_MEM  = 1'b0,
    PATCH_PROJ_MEM = 1'b1
  } MemRegion_t;

  localparam IntResAddr_t [1:0] mem_map = '{16'h1000, 16'h0000};

  typedef enum logic [1:0] {
    EEG_LDR_IDLE,
    EEG_LDR_LOADING,
    EEG_LDR_DONE
  } EegLoaderState_t;

  // Midscale removal then scale into the double-width fixed-point format.
  function automatic IntResDouble_t adc_to_int_res(
    input AdcData_t adc,
    input int       shift
  );
    logic [ADC_BITWIDTH:0] mid;
    logic [ADC_BITWIDTH:0] s;
    mid = ADC_MIDSCALE[ADC_BITWIDTH:0];
    s   = {1'b0, adc} - mid;
    return IntResDouble_t'(
      {{(INT_RES_DOUBLE_W-ADC_BITWIDTH-1){s[ADC_BITWIDTH]}}, s}
      << shift);
  endfunction

endpackage

// File: rtl/eeg_sample_loader_sample_fifo.sv
// sample_fifo: small circular buffer with full/empty flags and occupancy.
// Shared by all builds; EEG_SAMPLE_LOADER_CHECKSUM_EN does not affect it.
module sample_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full buffer succeeds only if a slot frees this cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/eeg_sample_loader.sv
// eeg_sample_loader: converts ADC samples to fixed point and streams them to memory.
// Optional checksum output is enabled by EEG_SAMPLE_LOADER_CHECKSUM_EN.
module eeg_sample_loader
  import eeg_sample_loader_pkg::*;
#(
  parameter int NUM_SAMPLES = EEG_NUM_SAMPLES,
  parameter int FIFO_DEPTH  = 4,
  parameter int SHIFT       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          adc_valid_i,
  input  AdcData_t      adc_data_i,
  output logic          mem_wr_en_o,
  input  logic          mem_wr_ready_i,
  output IntResAddr_t   mem_addr_o,
  output IntResDouble_t mem_data_o,
  output logic          busy_o,
  output logic          done_o,
`ifdef EEG_SAMPLE_LOADER_CHECKSUM_EN
  output logic [31:0]   checksum_o,
`endif
  output logic          overflow_o
);

  localparam int CW = $clog2(NUM_SAMPLES + 1);
  localparam int DW = $bits(IntResDouble_t);
  localparam int EW = CW + DW;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] NUM_C = CW'(NUM_SAMPLES);

  EegLoaderState_t state_q, state_d;
  logic [CW-1:0]   acc_cnt_q, acc_cnt_d;
  logic            ovf_q, ovf_d;
  logic            loading, launch, accept, hs, drop, last_wr;
  logic            fifo_full, fifo_empty;
  logic [OW-1:0]   fifo_cnt;
  logic [EW-1:0]   fifo_in, fifo_head;

  assign loading = state_q == EEG_LDR_LOADING;
  assign accept  = loading & adc_valid_i & (acc_cnt_q < NUM_C);
  assign hs      = mem_wr_en_o & mem_wr_ready_i;
  assign drop    = accept & fifo_full & ~hs;
  // Each entry carries its slot index, so a dropped sample skips its address.
  assign fifo_in = {acc_cnt_q, adc_to_int_res(adc_data_i, SHIFT)};
  assign last_wr = hs & (fifo_cnt == OW'(1)) & (acc_cnt_q == NUM_C);

  sample_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (launch),
    .push_i  (accept & ~drop),
    .pop_i   (hs),
    .data_i  (fifo_in),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign mem_wr_en_o = loading & ~fifo_empty;
  assign mem_addr_o  = mem_wr_en_o
    ? mem_map[EEG_INPUT_MEM] + IntResAddr_t'(fifo_head[EW-1:DW])
    : '0;
  assign mem_data_o  = mem_wr_en_o ? fifo_head[DW-1:0] : '0;
  assign overflow_o  = ovf_q;

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      EEG_LDR_IDLE: begin
        if (start_i) begin
          state_d = EEG_LDR_LOADING;
          launch  = 1'b1;
        end
      end
      EEG_LDR_LOADING: begin
        busy_o = 1'b1;
        if (last_wr) state_d = EEG_LDR_DONE;
      end
      EEG_LDR_DONE: begin
        done_o  = 1'b1;
        state_d = EEG_LDR_IDLE;
      end
      default: state_d = EEG_LDR_IDLE;
    endcase
  end

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    ovf_d     = ovf_q;
    if (launch) begin
      acc_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      if (accept) acc_cnt_d = acc_cnt_q + CW'(1);
      if (drop)   ovf_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EEG_LDR_IDLE;
      acc_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef EEG_SAMPLE_LOADER_CHECKSUM_EN
  logic [31:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (launch)      cks_d = '0;
    else if (accept) cks_d = cks_q + 32'(adc_data_i);
  end

  always_ff @(posedge clk) begin
    if (rst) cks_q <= '0;
    else     cks_q <= cks_d;
  end

  assign checksum_o = cks_q;
`endif

endmodule

// File: tb/tb_eeg_sample_loader.sv
// tb_eeg_sample_loader: directed bench for the EEG sample loader.
// Exercises the checksum path when EEG_SAMPLE_LOADER_CHECKSUM_EN is defined.
module tb_eeg_sample_loader;

  localparam int N = 3840;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        adc_valid;
  logic [15:0] adc_data;
  logic        mem_wr_en;
  logic        mem_wr_ready;
  logic [15:0] mem_addr;
  logic [29:0] mem_data;
  logic        busy;
  logic        done;
  logic        overflow;
`ifdef EEG_SAMPLE_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  eeg_sample_loader dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .adc_valid_i    (adc_valid),
    .adc_data_i     (adc_data),
    .mem_wr_en_o    (mem_wr_en),
    .mem_wr_ready_i (mem_wr_ready),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_data),
    .busy_o         (busy),
    .done_o         (done),
`ifdef EEG_SAMPLE_LOADER_CHECKSUM_EN
    .checksum_o     (checksum),
`endif
    .overflow_o     (overflow)
  );

  always #5 clk = ~clk;

  int          vecs = 0;
  int          errs = 0;
  int          cyc  = 0;
  int          nwr, last_addr, first_addr, last_hs;
  int          done_cyc, done_cnt, nwr_hold;
  bit          done_seen, chk_data;
  logic [31:0] cks_at_done;

  function automatic logic [15:0] slot_val(input int k);
    case (k)
      0:       return 16'h8000;
      1:       return 16'h0000;
      2:       return 16'hFFFF;
      3:       return 16'h8001;
      default: return 16'(k * 37) ^ 16'h5A5A;
    endcase
  endfunction

  function automatic logic [29:0] exp_data(input int k);
    int v;
    case (k)
      0:       return 30'h00000000;
      1:       return 30'h3FF80000;
      2:       return 30'h0007FFF0;
      3:       return 30'h00000010;
      default: begin
        v = (int'(slot_val(k)) - 32768) * 16;
        return v[29:0];
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    vecs++;
    assert (obs === want) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mem_wr_en && mem_wr_ready) begin
      chk("wr_addr_range", 32'(mem_addr < 16'(N)), 1);
      chk("wr_addr_incr", 32'(int'(mem_addr) > last_addr), 1);
      if (last_addr >= 0 && int'(mem_addr) != last_addr + 1)
        chk("gap_needs_ovf", 32'(overflow), 1);
      if (chk_data && mem_addr < 16'(N))
        chk("wr_data", 32'(mem_data), 32'(exp_data(int'(mem_addr))));
      chk("wr_after_done", 32'(done_seen), 0);
      if (first_addr < 0) first_addr = int'(mem_addr);
      nwr++;
      last_addr = int'(mem_addr);
      last_hs   = cyc;
    end
    if (done) begin
      done_seen = 1'b1;
      done_cnt++;
      done_cyc  = cyc;
`ifdef EEG_SAMPLE_LOADER_CHECKSUM_EN
      cks_at_done = checksum;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_run(input bit dchk);
    nwr        = 0;
    last_addr  = -1;
    first_addr = -1;
    done_cnt   = 0;
    done_seen  = 1'b0;
    chk_data   = dchk;
    start      = 1'b1;
    adc_valid  = 1'b1;
    adc_data   = 16'hDEAD;
    tick();
    start      = 1'b0;
    adc_valid  = 1'b0;
    chk("busy_on_start", 32'(busy), 1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) tick();
    chk("done_seen", 32'(done_seen), 1);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    adc_valid    = 1'b0;
    adc_data     = '0;
    mem_wr_ready = 1'b1;
    nwr          = 0;
    last_addr    = -1;
    first_addr   = -1;
    done_cnt     = 0;
    done_seen    = 1'b0;
    chk_data     = 1'b1;
    cks_at_done  = '0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_data", 32'(mem_data), 0);

    adc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      adc_data = 16'(i);
      tick();
    end
    adc_valid = 1'b0;
    chk("idle_no_wr", nwr, 0);
    chk("idle_ovf", 32'(overflow), 0);
    chk("idle_busy", 32'(busy), 0);

    // Basic load, one sample every 4 cycles.
    begin_run(1'b1);
    for (int k = 0; k < N; k++) begin
      adc_valid = 1'b1;
      adc_data  = slot_val(k);
      tick();
      adc_valid = 1'b0;
      if (k == 100) chk("a_busy", 32'(busy), 1);
      repeat (3) tick();
    end
    wait_done(20);
    chk("a_nwr", nwr, N);
    chk("a_first", first_addr, 0);
    chk("a_last", last_addr, N - 1);
    chk("a_done_lat", done_cyc - last_hs, 1);
    chk("a_ovf", 32'(overflow), 0);
    tick();
    chk("a_done_cnt", done_cnt, 1);
    chk("a_done_pulse", 32'(done), 0);
    chk("a_busy_after", 32'(busy), 0);

    // Back-pressure: sample every cycle, grant every third cycle.
    begin_run(1'b1);
    for (int k = 0; k < N; k++) begin
      adc_valid    = 1'b1;
      adc_data     = slot_val(k);
      mem_wr_ready = (cyc % 3 == 0);
      tick();
      if (k == 2) chk("b_ovf_early", 32'(overflow), 0);
    end
    adc_valid = 1'b0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      mem_wr_ready = (cyc % 3 == 0);
      tick();
    end
    chk("b_done_seen", 32'(done_seen), 1);
    mem_wr_ready = 1'b1;
    repeat (4) tick();
    chk("b_ovf", 32'(overflow), 1);
    chk("b_skipped", 32'(nwr < N), 1);
    chk("b_done_cnt", done_cnt, 1);
    chk("b_done_lat", done_cyc - last_hs, 1);
    chk("b_busy_after", 32'(busy), 0);

    // Extra samples past the window and a start pulse mid-load.
    begin_run(1'b1);
    mem_wr_ready = 1'b1;
    for (int k = 0; k < N + 3; k++) begin
      adc_valid = 1'b1;
      adc_data  = (k < N) ? slot_val(k) : 16'hBEEF;
      start     = (k == 2000);
      tick();
    end
    start     = 1'b0;
    adc_valid = 1'b0;
    wait_done(10);
    chk("c_nwr", nwr, N);
    chk("c_first", first_addr, 0);
    chk("c_last", last_addr, N - 1);
    chk("c_ovf", 32'(overflow), 0);
    chk("c_done_cnt", done_cnt, 1);
    chk("c_done_lat", done_cyc - last_hs, 1);

`ifdef EEG_SAMPLE_LOADER_CHECKSUM_EN
    begin_run(1'b0);
    for (int k = 0; k < N; k++) begin
      adc_valid = 1'b1;
      adc_data  = 16'h0001;
      tick();
    end
    adc_valid = 1'b0;
    wait_done(10);
    chk("e_nwr", nwr, N);
    chk("e_checksum", cks_at_done, 32'h00000F00);
`endif

    // Reset mid-load after overflow has been set.
    begin_run(1'b1);
    mem_wr_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      adc_valid = 1'b1;
      adc_data  = slot_val(k);
      tick();
    end
    chk("d_ovf_set", 32'(overflow), 1);
    mem_wr_ready = 1'b1;
    for (int k = 8; k < N && nwr < 1000; k++) begin
      adc_valid = 1'b1;
      adc_data  = slot_val(k);
      tick();
    end
    chk("d_nwr", nwr, 1000);
    rst = 1'b1;
    tick();
    chk("d_rst_wr_en", 32'(mem_wr_en), 0);
    chk("d_rst_busy", 32'(busy), 0);
    chk("d_rst_ovf", 32'(overflow), 0);
    rst      = 1'b0;
    nwr_hold = nwr;
    repeat (3) tick();
    adc_valid = 1'b0;
    chk("d_no_wr", nwr, nwr_hold);
    begin_run(1'b1);
    adc_valid = 1'b1;
    adc_data  = slot_val(0);
    tick();
    adc_valid = 1'b0;
    tick();
    chk("d_restart_nwr", nwr, 1);
    chk("d_restart_addr", first_addr, 0);
    chk("d_restart_ovf", 32'(overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/eeg_sample_loader.md
Name: eeg_sample_loader

Overview:
- Front-end stage for the EEG_LOAD state, upstream of patch projection.
- Accepts 16-bit unsigned ADC samples, converts each to double-width fixed point (EEG_FORMAT = INT_RES_DW_FX), and buffers them in a small FIFO.
- Writes them in order to intermediate-result memory starting at mem_map[EEG_INPUT_MEM].
- Signals completion after NUM_PATCHES*PATCH_LEN = 3840 samples.

Parameters:
- NUM_SAMPLES, 3840 (NUM_PATCHES*PATCH_LEN): samples per inference window.
- FIFO_DEPTH, 4: sample buffer entries; power of two, at least 2.
- SHIFT, 4: left shift applied after midscale removal.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse from the master FSM on entry to EEG_LOAD.
- adc_valid  in  1  ADC sample strobe; no back-pressure to the ADC.
- adc_data  in  16 (AdcData_t)  unsigned ADC sample.
- mem_wr_en  out  1  memory write request.
- mem_wr_ready  in  1  memory accepts the write this cycle (arbiter grant).
- mem_addr  out  IntResAddr_t  write address.
- mem_data  out  IntResDouble_t (30b)  converted sample.
- busy  out  1  high in LOADING.
- done  out  1  single-cycle pulse when the last write completes.
- overflow  out  1  sticky flag: a sample was dropped.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0; FIFO empty. A reset mid-load aborts immediately with no further writes.
- FSM states and transitions:
  - IDLE -> LOADING on start. Clears accept count, write count, FIFO and overflow.
  - LOADING -> DONE when the write with write count NUM_SAMPLES-1 handshakes (mem_wr_en & mem_wr_ready).
  - DONE -> IDLE the next cycle. done = 1 for exactly the DONE cycle.
  - start in LOADING or DONE is ignored.
- Sample acceptance:
  - Accept only in LOADING, only while accept count < NUM_SAMPLES.
  - adc_valid in IDLE/DONE, or after NUM_SAMPLES accepts, is dropped silently (no overflow).
- Conversion (combinational at push):
  - s = signed'({1'b0, adc_data}) - 32768, giving range [-32768, 32767].
  - mem_data = sign_extend_30(s) <<< SHIFT. With Q_STO_INT_RES_DOUBLE = 20, this represents s/65536 in [-0.5, 0.5).
  - No saturation is required; range is guaranteed by width.
- FIFO:
  - Push on accepted sample. Pop on write handshake.
  - Push while full: accepted only if a pop occurs in the same cycle. Otherwise the sample is dropped, overflow is set, and accept count still increments so the window stays aligned to the ADC.
  - Push and pop when empty in the same cycle is not a bypass: the sample is written the cycle after.
- Memory write:
  - mem_wr_en = LOADING & FIFO not empty.
  - mem_addr = mem_map[EEG_INPUT_MEM] + write count.
  - mem_data = FIFO head.
  - mem_addr and mem_data hold stable while mem_wr_en is high and mem_wr_ready is low.
- Latency: a sample accepted in cycle N is presented on mem_wr_en no earlier than N+1.
- Drops and termination: dropped samples are not written; their address slot is skipped (write count += 1 on drop). Exactly NUM_SAMPLES address slots are consumed, and done always fires.
- overflow holds until the next start or rst.

Optional Feature:
- Macro: EEG_SAMPLE_LOADER_CHECKSUM_EN.
- Defined: adds output checksum [31:0]. It is the modular sum of the raw adc_data over all accepted samples (dropped included), cleared on start, and valid when done pulses.
- Undefined: no checksum port or adder.

Decomposition:
- Add to Defines: EEG_NUM_SAMPLES (= NUM_PATCHES*PATCH_LEN), ADC_MIDSCALE (= 1 << (ADC_BITWIDTH-1)), EegLoaderState_t enum {EEG_LDR_IDLE, EEG_LDR_LOADING, EEG_LDR_DONE}.
- Reuse AdcData_t, IntResAddr_t, IntResDouble_t and mem_map.
- One sub-module, sample_fifo: parameterised width and depth, with push/pop, full/empty, and occupancy.

Test Plan:
- Basic load: start, then 3840 samples, one every 4 cycles, with mem_wr_ready tied 1. Expect 3840 writes at addresses 0..3839, sample 0x8000 -> mem_data 0, done one cycle after the last handshake, overflow 0.
- Conversion extremes: adc 0x0000 -> 30'h3FF80000 (-32768<<4); adc 0xFFFF -> 30'h0007FFF0; adc 0x8001 -> 30'h00000010.
- Back-pressure: adc_valid every cycle, mem_wr_ready 1 on every 3rd cycle, FIFO_DEPTH 4. Expect overflow to set on the first drop, the dropped slot's address skipped, done still after the 3840th slot, and no write after done.
- Idle/extra samples: adc_valid in IDLE and a 3841st sample in LOADING. Expect no writes, no overflow, count unaffected; start pulsed during LOADING is ignored.
- Reset mid-load: rst after 1000 writes. Expect mem_wr_en 0 next cycle, busy 0; a new start restarts at address 0 with overflow cleared.
- Checksum (macro defined): 3840 samples all 0x0001. Expect checksum 3840 (0x00000F00) at done.
